hazard_fwd_unit: RTL and testbench

- Consumer-side controller for the ID/EX pipeline register. It reads the ID/EX register outputs together with the EX/MEM and MEM/WB destination info.
- It drives the stall and bubble controls back into PC, IF/ID and ID/EX, and the EX-stage operand forwarding selects.
- A small FSM extends load-use stalls across a configurable number of cycles to cover slow data memory.

---
 rtl/hazard_fwd_unit.sv | 143 ++++++++++++++
 tb/tb_hazard_fwd_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - load-use stall FSM and EX-stage operand forwarding
// Optional macro HAZ_STATS_EN adds saturating stall_cnt / fwd_cnt counters.
module hazard_fwd_unit #(
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs_addr,
  input  logic [4:0]       id_rt_addr,
  input  logic             id_uses_rt,
  input  logic             ex_mem_r,
  input  logic [4:0]       ex_rs_addr,
  input  logic [4:0]       ex_rt_addr,
  input  logic             mem_reg_w,
  input  logic [4:0]       mem_dst_addr,
  input  logic             wb_reg_w,
  input  logic [4:0]       wb_dst_addr,
  input  logic             branch_flush,
  output logic             pc_w,
  output logic             if_id_w,
  output logic             id_ex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
`ifdef HAZ_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] fwd_cnt
`endif
);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  localparam logic       LONG_STALL = (LOAD_STALL > 1);
  localparam logic [3:0] STALL_INIT = 4'(LOAD_STALL - 1);

  if (LOAD_STALL < 1 || LOAD_STALL > 15 || CNT_W < 1) begin : g_param_check
    $error("hazard_fwd_unit: LOAD_STALL must be 1..15 and CNT_W >= 1");
  end

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       hz;
  logic       stalled;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic       m_w,
                                         input logic [4:0] m_dst,
                                         input logic       w_w,
                                         input logic [4:0] w_dst);
    logic [1:0] sel;
    sel = 2'b00;
    if (m_w && (m_dst != 5'd0) && (m_dst == src))
      sel = 2'b10;
    else if (w_w && (w_dst != 5'd0) && (w_dst == src))
      sel = 2'b01;
    return sel;
  endfunction

  assign hz = ex_mem_r && (ex_rt_addr != 5'd0) &&
              ((ex_rt_addr == id_rs_addr) || (id_uses_rt && (ex_rt_addr == id_rt_addr)));
  assign stalled   = (state_q == STALL) || hz;
  assign fwd_a_raw = fwd_sel(ex_rs_addr, mem_reg_w, mem_dst_addr, wb_reg_w, wb_dst_addr);
  assign fwd_b_raw = fwd_sel(ex_rt_addr, mem_reg_w, mem_dst_addr, wb_reg_w, wb_dst_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The hazard cycle itself is the first stall; STALL covers the remaining LOAD_STALL-1.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_w         = ~stalled;
    if_id_w      = ~stalled;
    id_ex_bubble = stalled;
    fwd_a        = fwd_a_raw;
    fwd_b        = fwd_b_raw;

    if (branch_flush) begin
      state_d = RUN;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (hz && LONG_STALL) begin
            state_d = STALL;
            cnt_d   = STALL_INIT;
          end
        end
        STALL: begin
          if (cnt_q == 4'd1) begin
            state_d = RUN;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = 4'd0;
        end
      endcase
    end

    if (branch_flush) begin
      pc_w         = 1'b1;
      if_id_w      = 1'b1;
      id_ex_bubble = 1'b1;
    end

    // Freeze the pipeline for as long as reset is held.
    if (!rst_n) begin
      pc_w         = 1'b0;
      if_id_w      = 1'b0;
      id_ex_bubble = 1'b1;
      fwd_a        = 2'b00;
      fwd_b        = 2'b00;
    end
  end

`ifdef HAZ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (stalled && !branch_flush && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (((fwd_a_raw != 2'b00) || (fwd_b_raw != 2'b00)) && (fwd_cnt != '1))
        fwd_cnt <= fwd_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb/tb_hazard_fwd_unit.sv - scoreboard bench for hazard_fwd_unit (LOAD_STALL 1 and 3)
module tb_hazard_fwd_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs_addr, id_rt_addr, ex_rs_addr, ex_rt_addr, mem_dst_addr, wb_dst_addr;
  logic       id_uses_rt, ex_mem_r, mem_reg_w, wb_reg_w, branch_flush;

  logic       pc_w1, if_id_w1, bub1, pc_w3, if_id_w3, bub3;
  logic [1:0] fwd_a1, fwd_b1, fwd_a3, fwd_b3;
`ifdef HAZ_STATS_EN
  logic [31:0] stall_cnt1, fwd_cnt1, stall_cnt3, fwd_cnt3;
`endif

  always #5 clk = ~clk;

  hazard_fwd_unit #(.LOAD_STALL(1), .CNT_W(32)) u1 (
    .clk(clk), .rst_n(rst_n), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_uses_rt(id_uses_rt), .ex_mem_r(ex_mem_r), .ex_rs_addr(ex_rs_addr),
    .ex_rt_addr(ex_rt_addr), .mem_reg_w(mem_reg_w), .mem_dst_addr(mem_dst_addr),
    .wb_reg_w(wb_reg_w), .wb_dst_addr(wb_dst_addr), .branch_flush(branch_flush),
    .pc_w(pc_w1), .if_id_w(if_id_w1), .id_ex_bubble(bub1), .fwd_a(fwd_a1), .fwd_b(fwd_b1)
`ifdef HAZ_STATS_EN
    , .stall_cnt(stall_cnt1), .fwd_cnt(fwd_cnt1)
`endif
  );

  hazard_fwd_unit #(.LOAD_STALL(3), .CNT_W(32)) u3 (
    .clk(clk), .rst_n(rst_n), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_uses_rt(id_uses_rt), .ex_mem_r(ex_mem_r), .ex_rs_addr(ex_rs_addr),
    .ex_rt_addr(ex_rt_addr), .mem_reg_w(mem_reg_w), .mem_dst_addr(mem_dst_addr),
    .wb_reg_w(wb_reg_w), .wb_dst_addr(wb_dst_addr), .branch_flush(branch_flush),
    .pc_w(pc_w3), .if_id_w(if_id_w3), .id_ex_bubble(bub3), .fwd_a(fwd_a3), .fwd_b(fwd_b3)
`ifdef HAZ_STATS_EN
    , .stall_cnt(stall_cnt3), .fwd_cnt(fwd_cnt3)
`endif
  );

  typedef struct {
    string      tag;
    logic       rst;
    logic [4:0] irs, irt;
    logic       use_rt, mr;
    logic [4:0] ers, ert;
    logic       mw;
    logic [4:0] md;
    logic       ww;
    logic [4:0] wd;
    logic       bf;
    logic       p1, b1, p3, b3;
    logic [1:0] fa, fb;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic add(input string tag, input logic rst, input logic [4:0] irs, irt,
                     input logic use_rt, mr, input logic [4:0] ers, ert, input logic mw,
                     input logic [4:0] md, input logic ww, input logic [4:0] wd, input logic bf,
                     input logic p1, b1, p3, b3, input logic [1:0] fa, fb);
    vec_t v;
    v.tag = tag; v.rst = rst; v.irs = irs; v.irt = irt; v.use_rt = use_rt; v.mr = mr;
    v.ers = ers; v.ert = ert; v.mw = mw; v.md = md; v.ww = ww; v.wd = wd; v.bf = bf;
    v.p1 = p1; v.b1 = b1; v.p3 = p3; v.b3 = b3; v.fa = fa; v.fb = fb;
    vecs.push_back(v);
  endtask

  task automatic nop(input string tag, input logic bf, input logic p1, b1, p3, b3);
    add(tag, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, bf,
        p1, b1, p3, b3, 2'b00, 2'b00);
  endtask

  // Load of $8 in EX while ID reads rs=$8.
  task automatic hz_row(input string tag, input logic bf, input logic p1, b1, p3, b3);
    add(tag, 1'b1, 5'd8, 5'd0, 1'b0, 1'b1, 5'd0, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0, bf,
        p1, b1, p3, b3, 2'b00, 2'b00);
  endtask

  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    rst_n = v.rst; id_rs_addr = v.irs; id_rt_addr = v.irt; id_uses_rt = v.use_rt;
    ex_mem_r = v.mr; ex_rs_addr = v.ers; ex_rt_addr = v.ert; mem_reg_w = v.mw;
    mem_dst_addr = v.md; wb_reg_w = v.ww; wb_dst_addr = v.wd; branch_flush = v.bf;
    exp_q.push_back(v);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      vec_t e;
      e = exp_q.pop_front();
      check({e.tag, ".u1.pc_w"},    {31'd0, pc_w1},    {31'd0, e.p1});
      check({e.tag, ".u1.if_id_w"}, {31'd0, if_id_w1}, {31'd0, e.p1});
      check({e.tag, ".u1.bubble"},  {31'd0, bub1},     {31'd0, e.b1});
      check({e.tag, ".u1.fwd_a"},   {30'd0, fwd_a1},   {30'd0, e.fa});
      check({e.tag, ".u1.fwd_b"},   {30'd0, fwd_b1},   {30'd0, e.fb});
      check({e.tag, ".u3.pc_w"},    {31'd0, pc_w3},    {31'd0, e.p3});
      check({e.tag, ".u3.if_id_w"}, {31'd0, if_id_w3}, {31'd0, e.p3});
      check({e.tag, ".u3.bubble"},  {31'd0, bub3},     {31'd0, e.b3});
      check({e.tag, ".u3.fwd_a"},   {30'd0, fwd_a3},   {30'd0, e.fa});
      check({e.tag, ".u3.fwd_b"},   {30'd0, fwd_b3},   {30'd0, e.fb});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n1;
    rst_n = 1'b0; id_rs_addr = '0; id_rt_addr = '0; id_uses_rt = 1'b0; ex_mem_r = 1'b0;
    ex_rs_addr = '0; ex_rt_addr = '0; mem_reg_w = 1'b0; mem_dst_addr = '0;
    wb_reg_w = 1'b0; wb_dst_addr = '0; branch_flush = 1'b0;

    // Reset held with hazard and forward-matching inputs: outputs must stay frozen.
    for (int i = 0; i < 3; i++)
      add("rst", 1'b0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd5, 5'd8, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0,
          1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00);
    nop("rel", 1'b0, 1, 0, 1, 0);
    hz_row("ls_hz", 1'b0, 0, 1, 0, 1);
    nop("ls_ext1", 1'b0, 1, 0, 0, 1);
    nop("ls_ext2", 1'b0, 1, 0, 0, 1);
    nop("ls_done", 1'b0, 1, 0, 1, 0);
    hz_row("bf_hz", 1'b0, 0, 1, 0, 1);
    nop("bf_stall", 1'b1, 1, 1, 1, 1);
    nop("bf_after", 1'b0, 1, 0, 1, 0);
    hz_row("bf_hzcyc", 1'b1, 1, 1, 1, 1);
    nop("bf_hzafter", 1'b0, 1, 0, 1, 0);
    hz_row("b2b_hz1", 1'b0, 0, 1, 0, 1);
    nop("b2b_s1", 1'b0, 1, 0, 0, 1);
    nop("b2b_s2", 1'b0, 1, 0, 0, 1);
    hz_row("b2b_hz2", 1'b0, 0, 1, 0, 1);
    nop("b2b_s3", 1'b0, 1, 0, 0, 1);
    nop("b2b_s4", 1'b0, 1, 0, 0, 1);
    nop("b2b_done", 1'b0, 1, 0, 1, 0);
    add("fwd_both", 1, 0, 0, 0, 0, 5, 0, 1, 5, 1, 5, 0, 1, 0, 1, 0, 2'b10, 2'b00);
    add("fwd_wb",   1, 0, 0, 0, 0, 5, 0, 0, 5, 1, 5, 0, 1, 0, 1, 0, 2'b01, 2'b00);
    add("fwd_r0",   1, 0, 0, 0, 0, 3, 0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00);
    add("fwd_bmem", 1, 0, 0, 0, 0, 7, 7, 1, 7, 0, 0, 0, 1, 0, 1, 0, 2'b10, 2'b10);
    add("fwd_bwb",  1, 0, 0, 0, 0, 4, 9, 1, 4, 1, 9, 0, 1, 0, 1, 0, 2'b10, 2'b01);
    add("ld_r0",    1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00);
    add("no_rt",    1, 3, 8, 0, 1, 0, 8, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00);
    add("rt_hz",    1, 3, 8, 1, 1, 0, 8, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00);
    nop("rt_s1", 1'b0, 1, 0, 0, 1);
    nop("rt_s2", 1'b0, 1, 0, 0, 1);
    nop("rt_done", 1'b0, 1, 0, 1, 0);
    n1 = vecs.size();
    hz_row("ab_hz", 1'b0, 0, 1, 0, 1);
    add("ab_rst", 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00);
    nop("ab_rel", 1'b0, 1, 0, 1, 0);
    nop("ab_run", 1'b0, 1, 0, 1, 0);

    for (int i = 0; i < n1; i++) apply(vecs[i]);
    @(posedge clk);
    #1;
    rst_n = 1'b1; id_rs_addr = '0; id_rt_addr = '0; id_uses_rt = 1'b0; ex_mem_r = 1'b0;
    ex_rs_addr = '0; ex_rt_addr = '0; mem_reg_w = 1'b0; mem_dst_addr = '0;
    wb_reg_w = 1'b0; wb_dst_addr = '0; branch_flush = 1'b0;
`ifdef HAZ_STATS_EN
    check("u1.stall_cnt", stall_cnt1, 32'd5);
    check("u3.stall_cnt", stall_cnt3, 32'd13);
    check("u1.fwd_cnt", fwd_cnt1, 32'd4);
    check("u3.fwd_cnt", fwd_cnt3, 32'd4);
`endif
    for (int i = n1; i < vecs.size(); i++) apply(vecs[i]);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
